matmul_tile_mem_ctrl: RTL

- Parametrised memory-side sequencer for the systolic matmul core. It owns the A, B and C single-port RAM interfaces.
- Host phase (idle): arbitrates host loads of A and B, and host readback of C.
- Compute phase (busy): sequences multi-tile runs. It streams SIZE rows of A and B per tile into the core, then writes the core's SIZE result rows into C at per-tile offsets.
- It replaces the fixed single-tile, two-clock wrapper with one clock, a tile loop, a registered host path and error reporting.

---
 rtl/matmul_tile_mem_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/matmul_tile_mem_ctrl.sv
// Memory-side sequencer for the systolic matmul core: host load/readback of the A/B/C RAMs
// while idle, and multi-tile feed of A/B rows plus capture of result rows into C while busy.
module matmul_tile_mem_ctrl #(
    parameter int DWIDTH = 8,
    parameter int SIZE   = 16,
    parameter int AWIDTH = 7,
    parameter int TWIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TWIDTH-1:0]      num_tiles,
    output logic                   busy,
    output logic                   done,
    output logic                   host_err,
    input  logic [AWIDTH-1:0]      host_addr,
    input  logic [SIZE*DWIDTH-1:0] host_wdata,
    input  logic                   host_we_a,
    input  logic                   host_we_b,
    input  logic                   host_re_c,
    output logic [SIZE*DWIDTH-1:0] host_rdata,
    output logic                   host_rvalid,
    output logic [AWIDTH-1:0]      a_addr,
    output logic [AWIDTH-1:0]      b_addr,
    output logic [AWIDTH-1:0]      c_addr,
    output logic                   a_we,
    output logic                   b_we,
    output logic                   c_we,
    output logic [SIZE*DWIDTH-1:0] ab_wdata,
    output logic [SIZE*DWIDTH-1:0] c_wdata,
    input  logic [SIZE*DWIDTH-1:0] a_rdata,
    input  logic [SIZE*DWIDTH-1:0] b_rdata,
    input  logic [SIZE*DWIDTH-1:0] c_rdata,
    output logic                   core_start,
    output logic                   core_in_valid,
    output logic [SIZE*DWIDTH-1:0] core_a_row,
    output logic [SIZE*DWIDTH-1:0] core_b_row,
    input  logic                   core_out_valid,
    input  logic [SIZE*DWIDTH-1:0] core_out_row
);

    // state     | meaning
    // ST_IDLE   | host owns the RAMs; waits for start
    // ST_FEED   | issues SIZE A/B row reads of the current tile
    // ST_WAIT   | collects remaining result rows, drains the feed pipeline
    // ST_FINISH | run complete; done pulses on the way back to idle
    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_WAIT, ST_FINISH} state_t;

    localparam int KW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int RW = $clog2(SIZE + 1);

    state_t            state;
    state_t            state_next;
    logic [TWIDTH-1:0] nt;
    logic [TWIDTH-1:0] t;
    logic [AWIDTH-1:0] base;
    logic [KW-1:0]     k;
    logic [RW-1:0]     r;
    logic [RW-1:0]     r_next;
    logic              feed_p1;
    logic              feed_p1_first;
    logic              rd_p1;
    logic              rd_p2;
    logic              host_any;
    logic              host_ok;
    logic              cap_ok;
    logic              more_tiles;
    logic              last_row;
    logic              tile_adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        host_any   = host_we_a | host_we_b | host_re_c;
        host_ok    = (state == ST_IDLE) && !start;
        cap_ok     = core_out_valid && ((state == ST_FEED) || (state == ST_WAIT)) && (r < RW'(SIZE));
        r_next     = r + RW'(cap_ok);
        more_tiles = ({1'b0, t} + (TWIDTH+1)'(1)) < {1'b0, nt};
        last_row   = (k == KW'(SIZE - 1));
        state_next = state;
        tile_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = (num_tiles == '0) ? ST_FINISH : ST_FEED;
            end
            ST_FEED: begin
                if (last_row) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // r_next lets the last result write and the tile decision share one edge
                if ((r_next == RW'(SIZE)) && !feed_p1) begin
                    if (more_tiles) begin
                        state_next = ST_FEED;
                        tile_adv   = 1'b1;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            host_err      <= 1'b0;
            host_rdata    <= '0;
            host_rvalid   <= 1'b0;
            a_addr        <= '0;
            b_addr        <= '0;
            c_addr        <= '0;
            a_we          <= 1'b0;
            b_we          <= 1'b0;
            c_we          <= 1'b0;
            ab_wdata      <= '0;
            c_wdata       <= '0;
            core_start    <= 1'b0;
            core_in_valid <= 1'b0;
            core_a_row    <= '0;
            core_b_row    <= '0;
            nt            <= '0;
            t             <= '0;
            base          <= '0;
            k             <= '0;
            r             <= '0;
            feed_p1       <= 1'b0;
            feed_p1_first <= 1'b0;
            rd_p1         <= 1'b0;
            rd_p2         <= 1'b0;
        end else begin
            a_we          <= 1'b0;
            b_we          <= 1'b0;
            c_we          <= 1'b0;
            busy          <= (state_next != ST_IDLE);
            done          <= (state == ST_FINISH);
            feed_p1       <= (state == ST_FEED);
            feed_p1_first <= (state == ST_FEED) && (k == '0);
            core_in_valid <= feed_p1;
            core_start    <= feed_p1_first;
            if (feed_p1) begin
                core_a_row <= a_rdata;
                core_b_row <= b_rdata;
            end
            rd_p1       <= host_ok && host_re_c;
            rd_p2       <= rd_p1;
            host_rvalid <= rd_p2;
            if (rd_p2) host_rdata <= c_rdata;

            if (host_ok) begin
                if (host_we_a || host_we_b) begin
                    a_we     <= host_we_a;
                    b_we     <= host_we_b;
                    a_addr   <= host_addr;
                    b_addr   <= host_addr;
                    ab_wdata <= host_wdata;
                end
                if (host_re_c) c_addr <= host_addr;
            end

            if ((state == ST_IDLE) && start) begin
                nt       <= num_tiles;
                t        <= '0;
                base     <= '0;
                k        <= '0;
                r        <= '0;
                a_addr   <= '0;
                b_addr   <= '0;
                host_err <= 1'b0;
            end

            if (state == ST_FEED) begin
                if (last_row) begin
                    k <= '0;
                end else begin
                    k      <= k + KW'(1);
                    a_addr <= base + AWIDTH'(k) + AWIDTH'(1);
                    b_addr <= base + AWIDTH'(k) + AWIDTH'(1);
                end
            end

            if (cap_ok) begin
                c_we    <= 1'b1;
                c_addr  <= base + AWIDTH'(r);
                c_wdata <= core_out_row;
                r       <= r_next;
            end

            if (tile_adv) begin
                t      <= t + TWIDTH'(1);
                base   <= base + AWIDTH'(SIZE);
                r      <= '0;
                a_addr <= base + AWIDTH'(SIZE);
                b_addr <= base + AWIDTH'(SIZE);
            end

            // placed last so an error in the start cycle survives the clear above
            if ((host_any && !host_ok) || (core_out_valid && !cap_ok)) host_err <= 1'b1;
        end
    end

endmodule
